// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioner: FSM states,
// one-hot command vector layout and the command priority encoder.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, WAIT_FALL} state_t;

    typedef logic [3:0] cmd_t;

    localparam int CMD_SET   = 3;
    localparam int CMD_SHR   = 2;
    localparam int CMD_SHL   = 1;
    localparam int CMD_DCRM  = 0;
    localparam int BTN_PAUSE = 4;

    // Keep only the highest-priority request: set > shift_right1 > shift_left2 > dcrm.
    function automatic cmd_t pick_cmd(input cmd_t req);
        cmd_t one_hot;
        one_hot = '0;
        if (req[CMD_SET])       one_hot[CMD_SET]  = 1'b1;
        else if (req[CMD_SHR])  one_hot[CMD_SHR]  = 1'b1;
        else if (req[CMD_SHL])  one_hot[CMD_SHL]  = 1'b1;
        else if (req[CMD_DCRM]) one_hot[CMD_DCRM] = 1'b1;
        return one_hot;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Synchronizes one raw active-low button, filters bounce with a stability
// counter and emits a single-cycle pulse on each accepted press.
module debouncer #(
    parameter int P_DEBOUNCE = 50000,
    parameter int P_CNT_W    = 16
) (
    input  logic i_clk,
    input  logic reset,
    input  logic din_n,
    output logic stable,
    output logic press
);

    localparam logic [P_CNT_W-1:0] LAST = P_CNT_W'(P_DEBOUNCE - 1);

    logic [1:0]         sync;
    logic [P_CNT_W-1:0] cnt;
    logic               stable_d;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            sync     <= 2'b11;
            cnt      <= '0;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            sync     <= {sync[0], din_n};
            stable_d <= stable;
            press    <= stable_d & ~stable;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Turns bouncing push-buttons into counter commands, each held across exactly
// one rising edge of the divided clock o_clk, plus a toggled pause level.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int P_DEBOUNCE = 50000,
    parameter int P_CNT_W    = 16
) (
    input  logic i_clk,
    input  logic reset,
    input  logic o_clk,
    input  logic btn_set_n,
    input  logic btn_dcrm_n,
    input  logic btn_shl_n,
    input  logic btn_shr_n,
    input  logic btn_pause_n,
    output logic set,
    output logic dcrm,
    output logic shift_left2,
    output logic shift_right1,
    output logic input_pause,
    output logic cmd_busy
);

    logic [4:0] raw_n;
    logic [4:0] press;
    logic [4:0] unused_levels;
    logic [1:0] ck_sync;
    logic       ck_s;
    cmd_t       cmd_req;
    cmd_t       cmd;
    state_t     state;
    state_t     next_state;

    // Bit positions line up with the CMD_* indices; pause sits on top.
    assign raw_n   = {btn_pause_n, btn_set_n, btn_shr_n, btn_shl_n, btn_dcrm_n};
    assign cmd_req = press[3:0];
    assign ck_s    = ck_sync[1];

    for (genvar gi = 0; gi < 5; gi++) begin : g_deb
        debouncer #(
            .P_DEBOUNCE(P_DEBOUNCE),
            .P_CNT_W   (P_CNT_W)
        ) u_deb (
            .i_clk (i_clk),
            .reset (reset),
            .din_n (raw_n[gi]),
            .stable(unused_levels[gi]),
            .press (press[gi])
        );
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) ck_sync <= 2'b00;
        else        ck_sync <= {ck_sync[0], o_clk};
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (|cmd_req) next_state = WAIT_LOW;
            WAIT_LOW:  if (!ck_s)    next_state = WAIT_HIGH;
            WAIT_HIGH: if (ck_s)     next_state = WAIT_FALL;
            WAIT_FALL: if (!ck_s)    next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Command is latched on acceptance and dropped once the low phase after the rise is seen.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            cmd <= '0;
        end else if (state == IDLE && |cmd_req) begin
            cmd <= pick_cmd(cmd_req);
        end else if (state == WAIT_FALL && !ck_s) begin
            cmd <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset)                input_pause <= 1'b0;
        else if (press[BTN_PAUSE]) input_pause <= ~input_pause;
    end

    always_comb begin
        set          = cmd[CMD_SET];
        shift_right1 = cmd[CMD_SHR];
        shift_left2  = cmd[CMD_SHL];
        dcrm         = cmd[CMD_DCRM];
        cmd_busy     = (state != IDLE);
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of the DUT counter. It takes raw, bouncing, active-low push-buttons and produces clean control signals for the counter: set, dcrm, shift_left2 and shift_right1, plus the input_pause level. Each command is held across exactly one rising edge of the divided clock o_clk, because the counter only samples on that edge. The block runs on the fast i_clk and samples o_clk as data.

Parameters:
P_DEBOUNCE, 50000, number of consecutive stable i_clk cycles needed to accept a button level change (1 ms at 50 MHz).
P_CNT_W, 16, width of each debounce counter; must satisfy 2^P_CNT_W > P_DEBOUNCE.

Ports:
i_clk  input  1  system clock (undivided).
reset  input  1  asynchronous, active-low reset.
o_clk  input  1  divided clock from ClockDivider, sampled as data.
btn_set_n  input  1  raw button, 0 = pressed.
btn_dcrm_n  input  1  raw button, 0 = pressed.
btn_shl_n  input  1  raw button, 0 = pressed.
btn_shr_n  input  1  raw button, 0 = pressed.
btn_pause_n  input  1  raw button, 0 = pressed.
set  output  1  command to counter, active-high.
dcrm  output  1  command to counter, active-high.
shift_left2  output  1  command to counter, active-high.
shift_right1  output  1  command to counter, active-high.
input_pause  output  1  pause level to counter, 1 = paused.
cmd_busy  output  1  high while a command is being delivered.

Behaviour:
- Reset (reset = 0, asynchronous): all outputs 0, FSM in IDLE, debounce counters 0, stable levels = released, synchronizers = 1 (o_clk synchronizer = 0).
- Synchronizers: 2-flop synchronizer on each button and on o_clk. Synchronized o_clk is called ck_s.
- Debounce, per button:
  - Counter clears whenever the synchronized input equals the stable level.
  - Otherwise the counter increments. When it reaches P_DEBOUNCE-1, the stable level takes the input value and the counter clears.
  - A press event is a single-cycle pulse on a stable released-to-pressed transition. Release produces no event.
  - Latency from the raw edge to the press event is P_DEBOUNCE + 3 i_clk cycles.
- Pause: input_pause toggles on each pause press event. It is independent of the FSM and unaffected by pending commands.
- Command FSM, states IDLE, WAIT_LOW, WAIT_HIGH, WAIT_FALL:
  - IDLE: on any command press event, latch a one-hot cmd register and go to WAIT_LOW. Simultaneous events resolve by priority set > shift_right1 > shift_left2 > dcrm; lower-priority events are dropped.
  - WAIT_LOW: when ck_s = 0, go to WAIT_HIGH.
  - WAIT_HIGH: when ck_s = 1, go to WAIT_FALL.
  - WAIT_FALL: when ck_s = 0, clear cmd and go to IDLE.
  - The command output equals the corresponding cmd bit. It asserts in the cycle after the press event and deasserts the cycle after ck_s is seen low in WAIT_FALL.
  - cmd_busy = (state != IDLE).
- Command presses in any state other than IDLE are dropped (no queue).
- Guarantee: each command is high across exactly one real o_clk rising edge, given an o_clk half-period of at least 4 i_clk cycles.
- Reset mid-delivery: command drops immediately and the FSM returns to IDLE; input_pause clears to 0.
- A button held indefinitely produces exactly one press event.

Decomposition:
- Package btn_pkg:
  - typedef enum logic[1:0] state_t {IDLE, WAIT_LOW, WAIT_HIGH, WAIT_FALL}.
  - typedef logic[3:0] cmd_t, one-hot.
  - Bit-index constants CMD_SET=3, CMD_SHR=2, CMD_SHL=1, CMD_DCRM=0.
- Sub-module debouncer (parameters P_DEBOUNCE, P_CNT_W; ports i_clk, reset, din_n, stable, press), instantiated 5 times. The FSM, priority logic and o_clk synchronizer stay in the top.

Test Plan (P_DEBOUNCE = 4, o_clk period = 20 i_clk):
- Bounce: btn_set_n toggles 0/1 every 2 cycles for 12 cycles, then holds 0 -> exactly one press event; set high across exactly one o_clk rise, then 0; cmd_busy mirrors set.
- Priority: btn_set_n and btn_shl_n fall in the same cycle -> only set asserts; shift_left2 stays 0 throughout.
- Drop while busy: dcrm press, then shr press arriving during WAIT_HIGH -> dcrm delivered once; shift_right1 never asserts.
- Phase: press latched while ck_s = 1 -> FSM passes WAIT_LOW, waits for the next rise; output covers that next rise only (counter model sees 1 dcrm).
- Pause: three pause presses -> input_pause goes 0 -> 1 -> 0 -> 1; a simultaneous shl press is still delivered.
- Reset mid-op: reset = 0 in WAIT_HIGH with shift_right1 high -> outputs 0 in the same cycle (asynchronous); after release, FSM is IDLE and input_pause = 0.
